// File: rtl/call_stack_pkg.sv
// Shared constants and the decoder-strobe encoding for the hardware return-address stack.
package call_stack_pkg;

    localparam int CSTK_DEPTH = 16;
    localparam int CSTK_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_POP,
        OP_PUSH,
        OP_REPLACE
    } cstk_op_e;

    function automatic cstk_op_e decode_op(input logic cpush, input logic cpop);
        case ({cpush, cpop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPLACE;
            default: return OP_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address stack: registered top entry plus a distributed-RAM array of the entries below it.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH = CSTK_DEPTH,
    parameter int WIDTH = CSTK_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpush,
    input  logic                     cpop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-2];
    logic [WIDTH-1:0] top_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;

    cstk_op_e         op;
    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] below_top;
    logic             mem_we;

    assign op        = decode_op(cpush, cpop);
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == FULL);
    assign rd_idx    = AW'(count_q - TWO);
    assign wr_idx    = AW'(count_q - ONE);
    assign below_top = mem[rd_idx];
    assign mem_we    = !rst && (op == OP_PUSH) && !is_full && !is_empty;

    // NOTE: the array is deliberately not reset; entries above count are never read,
    // and leaving out the reset lets it map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= top_q;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (op)
                OP_HOLD: begin
                end
                OP_PUSH: begin
                    if (is_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        top_q   <= push_data;
                        count_q <= count_q + ONE;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        underflow_q <= 1'b1;
                    end else if (count_q == ONE) begin
                        top_q   <= '0;
                        count_q <= '0;
                    end else begin
                        top_q   <= below_top;
                        count_q <= count_q - ONE;
                    end
                end
                OP_REPLACE: begin
                    // On an empty stack a replace degenerates into a plain push.
                    top_q <= push_data;
                    if (is_empty) begin
                        count_q <= ONE;
                    end
                end
            endcase
        end
    end

    assign top       = top_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed vector table, corner-case sequences, randomized run against a queue model.
module tb_call_stack;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             cpush;
    logic             cpop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top;
    logic [4:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue whose last element is the top of stack.
    int unsigned m_q[$];
    bit          m_ovf;
    bit          m_udf;

    call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpush     (cpush),
        .cpop      (cpop),
        .push_data (push_data),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          p;
        bit          o;
        logic [15:0] d;
        logic [15:0] e_top;
        int          e_count;
        bit          e_empty;
        bit          e_full;
        bit          e_ovf;
        bit          e_udf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned model_top();
        return (m_q.size() == 0) ? 0 : m_q[m_q.size()-1];
    endfunction

    task automatic model_step(input bit p, input bit o, input bit r, input logic [15:0] d);
        if (r) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (p && !o) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back(d);
        end else if (o && !p) begin
            if (m_q.size() == 0) m_udf = 1;
            else void'(m_q.pop_back());
        end else if (p && o) begin
            if (m_q.size() == 0) m_q.push_back(d);
            else m_q[m_q.size()-1] = d;
        end
    endtask

    // Drive one cycle's strobes, clock it, and leave outputs settled 1 time unit after the edge.
    task automatic cycle(input bit p, input bit o, input bit r, input logic [15:0] d);
        cpush     = p;
        cpop      = o;
        rst       = r;
        push_data = d;
        @(posedge clk);
        model_step(p, o, r, d);
        #1;
        cpush = 1'b0;
        cpop  = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".top"},   32'(top),       32'(model_top()));
        check({tag, ".count"}, 32'(count),     32'(m_q.size()));
        check({tag, ".empty"}, 32'(empty),     32'(m_q.size() == 0));
        check({tag, ".full"},  32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, ".udf"},   32'(underflow), 32'(m_udf));
    endtask

    initial begin
        vec_t vecs[$];
        cpush = 0; cpop = 0; rst = 0; push_data = '0;

        cycle(0, 0, 1, 16'h0);
        cycle(0, 0, 1, 16'h0);

        //            p  o  data      top      cnt e  f  ov ud
        vecs.push_back('{0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h0102, 16'h0102, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h0204, 16'h0204, 2, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h0306, 16'h0306, 3, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0204, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0102, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h0020, 16'h0020, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 16'h0040, 16'h0040, 2, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 16'h0080, 16'h0080, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0020, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 1, 16'h0055, 16'h0055, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(vecs[i].p, vecs[i].o, 1'b0, vecs[i].d);
            check({tag, ".top"},   32'(top),       32'(vecs[i].e_top));
            check({tag, ".count"}, 32'(count),     32'(vecs[i].e_count));
            check({tag, ".empty"}, 32'(empty),     32'(vecs[i].e_empty));
            check({tag, ".full"},  32'(full),      32'(vecs[i].e_full));
            check({tag, ".ovf"},   32'(overflow),  32'(vecs[i].e_ovf));
            check({tag, ".udf"},   32'(underflow), 32'(vecs[i].e_udf));
        end

        // Fill to capacity, then overflow.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 16'(16'h1000 + 2 * i));
        check("fill.full",  32'(full),  32'd1);
        check("fill.top",   32'(top),   32'h101E);
        check("fill.count", 32'(count), 32'd16);
        cycle(1, 0, 0, 16'hBEEF);
        check("ovf.flag",  32'(overflow), 32'd1);
        check("ovf.top",   32'(top),      32'h101E);
        check("ovf.count", 32'(count),    32'd16);

        // Pops: top is the jump target during the pop cycle, before the edge.
        for (int k = 0; k < DEPTH; k++) begin
            cpop = 1'b1;
            #1;
            check($sformatf("pop%0d.target", k), 32'(top), 32'(16'h1000 + 2 * (DEPTH - 1 - k)));
            cycle(0, 1, 0, 16'h0);
        end
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.top",   32'(top),   32'h0);
        check("drain.udf",   32'(underflow), 32'd0);

        // Underflow is sticky through idle cycles.
        cycle(0, 1, 0, 16'h0);
        check("udf.flag",  32'(underflow), 32'd1);
        check("udf.top",   32'(top),       32'h0);
        check("udf.count", 32'(count),     32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 16'h0);
            check($sformatf("udf.sticky%0d", i), 32'(underflow), 32'd1);
        end
        check("ovf.sticky", 32'(overflow), 32'd1);

        // Reset beats a simultaneous push.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 16'(16'h0A00 + i));
        check("pre_rst.count", 32'(count), 32'd5);
        cycle(1, 0, 1, 16'h7777);
        check("rst.count", 32'(count),     32'd0);
        check("rst.top",   32'(top),       32'h0);
        check("rst.ovf",   32'(overflow),  32'd0);
        check("rst.udf",   32'(underflow), 32'd0);
        check_model("rst");

        // Randomized run with phases biased toward pushing or popping.
        for (int n = 0; n < 3000; n++) begin
            int unsigned push_bias;
            int unsigned r;
            bit p, o, rr;
            push_bias = ((n / 250) % 2 == 0) ? 70 : 30;
            r  = $urandom_range(99);
            rr = ($urandom_range(499) == 0);
            p  = (r < push_bias);
            o  = ($urandom_range(99) < (100 - push_bias));
            cycle(p, o, rr, 16'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
